// File: rtl/lstm_cram.sv
// Cell-state RAM for an LSTM datapath: clears all entries per sequence, streams c_{t-1}
// to compute and writes back c_t. Optional macro: LSTM_CRAM_BYPASS_EN (write-to-read forwarding).
module lstm_cram #(
    parameter int N_HIDDEN   = 32,
    parameter int DATA_BITS  = 16,
    parameter int RD_LATENCY = 5,
    parameter int WB_DELAY   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 seq_start,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    output logic [DATA_BITS-1:0] cram_data,
    output logic                 cram_valid,
    input  logic [DATA_BITS-1:0] wb_data,
    output logic                 step_done,
    output logic                 busy
);
    localparam int IDX_W = $clog2(N_HIDDEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HIDDEN - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_clr_idx, r_rd_idx;
    logic [DATA_BITS-1:0]   r_mem [N_HIDDEN];
    logic [RD_LATENCY-2:0]  r_rd_v;
    logic [IDX_W-1:0]       r_rd_pipe [RD_LATENCY-1];
    logic                   r_cram_valid;
    logic [DATA_BITS-1:0]   r_cram_data;
    logic [IDX_W-1:0]       r_cram_idx;
    logic [WB_DELAY-1:0]    r_wb_v;
    logic [IDX_W-1:0]       r_wb_pipe [WB_DELAY];

    logic                   w_issue, w_rd_now, w_wb_we, w_mem_we;
    logic [IDX_W-1:0]       w_rd_addr, w_wb_addr, w_mem_addr;
    logic [DATA_BITS-1:0]   w_rd_data, w_mem_wdata;

    // The RAM is read one cycle before cram_valid so cram_data can be registered.
    assign w_rd_now  = r_rd_v[RD_LATENCY-2];
    assign w_rd_addr = r_rd_pipe[RD_LATENCY-2];
    assign w_wb_addr = r_wb_pipe[WB_DELAY-1];
    assign w_wb_we   = r_wb_v[WB_DELAY-1] && !seq_start && !reset;

`ifdef LSTM_CRAM_BYPASS_EN
    assign w_rd_data = (w_wb_we && (w_wb_addr == w_rd_addr)) ? wb_data : r_mem[w_rd_addr];
`else
    assign w_rd_data = r_mem[w_rd_addr];
`endif

    assign cram_data  = r_cram_data;
    assign cram_valid = r_cram_valid;
    assign step_done  = w_wb_we && (w_wb_addr == LAST_IDX);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        busy        = 1'b0;
        issue_ready = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_CLEAR: begin
                busy = 1'b1;
                if (!seq_start && (r_clr_idx == LAST_IDX)) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                issue_ready = !seq_start;
                w_issue     = issue_valid && !seq_start;
                if (seq_start) w_state_nxt = S_CLEAR;
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Single write port, shared between clearing and writeback.
    always_comb begin
        w_mem_we    = w_wb_we;
        w_mem_addr  = w_wb_addr;
        w_mem_wdata = wb_data;
        if (r_state == S_CLEAR) begin
            w_mem_we    = !reset;
            w_mem_addr  = r_clr_idx;
            w_mem_wdata = '0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state      <= S_CLEAR;
            r_clr_idx    <= '0;
            r_rd_idx     <= '0;
            r_rd_v       <= '0;
            r_cram_valid <= 1'b0;
            r_cram_data  <= '0;
            r_wb_v       <= '0;
        end else if (seq_start) begin
            r_state      <= w_state_nxt;
            r_clr_idx    <= '0;
            r_rd_idx     <= '0;
            r_rd_v       <= '0;
            r_cram_valid <= 1'b0;
            r_wb_v       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR)
                r_clr_idx <= (r_clr_idx == LAST_IDX) ? '0 : r_clr_idx + IDX_W'(1);
            if (w_issue)
                r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + IDX_W'(1);
            r_rd_v       <= (RD_LATENCY-1)'({r_rd_v, w_issue});
            r_cram_valid <= w_rd_now;
            if (w_rd_now) r_cram_data <= w_rd_data;
            r_wb_v       <= WB_DELAY'({r_wb_v, r_cram_valid});
        end
    end

    // NOTE: the RAM and index pipes carry no reset; valid bits and CLEAR make stale contents harmless.
    always_ff @(posedge clock) begin
        r_rd_pipe[0] <= r_rd_idx;
        for (int i = 1; i < RD_LATENCY - 1; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
        r_cram_idx   <= w_rd_addr;
        r_wb_pipe[0] <= r_cram_idx;
        for (int i = 1; i < WB_DELAY; i++) r_wb_pipe[i] <= r_wb_pipe[i-1];
    end

    always_ff @(posedge clock) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    end
endmodule

// File: tb/tb_lstm_cram.sv
// Self-checking bench for lstm_cram: directed phases plus random traffic, compared every
// cycle against an event-queue model of when each unit is read and written back.
module tb_lstm_cram;
    localparam int N  = 32;
    localparam int RL = 5;
    localparam int WB = 4;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset, seq_start, issue_valid;
    logic          issue_ready, cram_valid, step_done, busy;
    logic [DW-1:0] cram_data, wb_data;

    always #5 clock = ~clock;

    lstm_cram #(.N_HIDDEN(N), .DATA_BITS(DW), .RD_LATENCY(RL), .WB_DELAY(WB)) dut (
        .clock      (clock),
        .reset      (reset),
        .seq_start  (seq_start),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .cram_data  (cram_data),
        .cram_valid (cram_valid),
        .wb_data    (wb_data),
        .step_done  (step_done),
        .busy       (busy)
    );

    typedef struct {
        int            idx;
        int            due;
        logic [DW-1:0] data;
    } ev_t;

    ev_t           reads[$];   // due = cycle the RAM is sampled (issue + RL - 1)
    ev_t           shows[$];   // due = cycle cram_valid is expected high
    ev_t           writes[$];  // due = writeback cycle (issue + RL + WB)
    logic [DW-1:0] mmem [N];
    int            clear_left, next_idx, cyc;
    logic [DW-1:0] last_data;
    bit            pat_mode, armed;
    int            checks = 0;
    int            failures = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", name, cyc, obs, exp);
        end
    endtask

    task automatic tick(input bit rst, input bit s, input bit v);
        bit            e_valid, e_done, e_ready, e_busy, wr_now;
        int            wr_idx;
        logic [DW-1:0] e_data, cap;
        ev_t           e;
        @(negedge clock);
        reset       = rst;
        seq_start   = s;
        issue_valid = v;
        wr_now = 1'b0;
        wr_idx = 0;
        if (writes.size() > 0 && writes[0].due == cyc) begin
            wr_now = 1'b1;
            wr_idx = writes[0].idx;
        end
        if (wr_now && pat_mode) wb_data = 16'(16'h0100 + wr_idx);
        else                    wb_data = 16'($urandom);
        #1;
        e_valid = shows.size() > 0 && shows[0].due == cyc;
        if (armed) begin
            e_busy  = clear_left > 0;
            e_ready = clear_left == 0 && !s;
            e_data  = e_valid ? shows[0].data : last_data;
            e_done  = wr_now && !s && !rst && wr_idx == N - 1;
            check("busy", 32'(busy), 32'(e_busy));
            check("issue_ready", 32'(issue_ready), 32'(e_ready));
            check("cram_valid", 32'(cram_valid), 32'(e_valid));
            check("cram_data", 32'(cram_data), 32'(e_data));
            check("step_done", 32'(step_done), 32'(e_done));
            last_data = e_data;
        end
        if (e_valid) void'(shows.pop_front());

        if (rst || s) begin
            reads.delete();
            shows.delete();
            writes.delete();
            clear_left = N;
            next_idx   = 0;
            foreach (mmem[i]) mmem[i] = '0;
            if (rst) begin
                last_data = '0;
                armed     = 1'b1;
            end
        end else begin
            while (reads.size() > 0 && reads[0].due == cyc) begin
                cap = mmem[reads[0].idx];
`ifdef LSTM_CRAM_BYPASS_EN
                if (wr_now && wr_idx == reads[0].idx) cap = wb_data;
`endif
                e.idx  = reads[0].idx;
                e.due  = cyc + 1;
                e.data = cap;
                shows.push_back(e);
                void'(reads.pop_front());
            end
            if (wr_now) begin
                mmem[wr_idx] = wb_data;
                void'(writes.pop_front());
            end
            if (clear_left > 0) clear_left--;
            else if (v) begin
                e.idx  = next_idx;
                e.data = '0;
                e.due  = cyc + RL - 1;
                reads.push_back(e);
                e.due  = cyc + RL + WB;
                writes.push_back(e);
                next_idx = (next_idx + 1) % N;
            end
        end
        cyc++;
    endtask

    initial begin
        reset       = 1'b1;
        seq_start   = 1'b0;
        issue_valid = 1'b0;
        wb_data     = '0;
        armed       = 1'b0;
        pat_mode    = 1'b0;
        cyc         = 0;
        last_data   = '0;

        // Reset, then the 32-cycle clear with nothing issued.
        tick(1, 0, 0);
        tick(1, 0, 0);
        repeat (32) tick(0, 0, 0);

        // Step 1: all reads zero, writeback 0x0100+index.
        pat_mode = 1'b1;
        repeat (32) tick(0, 0, 1);
        repeat (12) tick(0, 0, 0);

        // Step 2 reads back 0x0100..0x011F; random writebacks from here on.
        pat_mode = 1'b0;
        repeat (32) tick(0, 0, 1);
        repeat (12) tick(0, 0, 0);

        // Bubble every third cycle.
        for (int i = 0; i < 48; i++) tick(0, 0, (i % 3) != 2);
        repeat (12) tick(0, 0, 0);

        // Long back-to-back run across step boundaries.
        repeat (64) tick(0, 0, 1);
        repeat (12) tick(0, 0, 0);

        // seq_start three cycles into a step, then a full step of zeros.
        repeat (3) tick(0, 0, 1);
        tick(0, 1, 1);
        repeat (34) tick(0, 0, 0);
        repeat (32) tick(0, 0, 1);
        repeat (12) tick(0, 0, 0);

        // seq_start in the middle of CLEAR restarts clearing; issues there are ignored.
        tick(0, 1, 0);
        repeat (10) tick(0, 0, 1);
        tick(0, 1, 1);
        repeat (33) tick(0, 0, 1);
        repeat (12) tick(0, 0, 0);

        // Random traffic with occasional new sequences.
        for (int i = 0; i < 400; i++) tick(0, ($urandom % 97) == 0, ($urandom % 4) != 0);
        repeat (12) tick(0, 0, 0);

        // Reset in the middle of a step discards in-flight work.
        repeat (5) tick(0, 0, 1);
        tick(1, 0, 1);
        repeat (34) tick(0, 0, 1);
        repeat (12) tick(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
